// File: rtl/aud_player_stereo.sv
// Stereo I2S DAC serializer running entirely in the codec bit-clock domain.
// Sample pairs enter a small FIFO; each left-frame start pops one pair and serialises it MSB-first.
module aud_player_stereo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          i_bclk,
    input  logic                          i_rst,
    input  logic                          i_daclrck,
    input  logic                          i_en,
    input  logic                          i_mute,
    input  logic                          i_mono,
    input  logic                          i_valid,
    input  logic [DATA_W-1:0]             i_data_l,
    input  logic [DATA_W-1:0]             i_data_r,
    output logic                          o_ready,
    output logic                          o_aud_dacdat,
    output logic                          o_underrun,
    output logic [CNT_W-1:0]              o_underrun_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BITS_L  = BW'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    state_t              state_q, state_d;
    logic                lrck_q;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   r_hold_q, r_hold_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                dac_q, dac_d;
    logic                underrun_q, underrun_d;
    logic [CNT_W-1:0]    urun_cnt_q, urun_cnt_d;

    logic [DATA_W-1:0]   mem_l [FIFO_DEPTH];
    logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [LW-1:0]       level_q;

    logic                edge_l;
    logic                edge_r;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                do_load;
    logic [DATA_W-1:0]   load_word;
    logic [DATA_W-1:0]   head_l;
    logic [DATA_W-1:0]   head_r;

    assign edge_l     = !i_daclrck && lrck_q;
    assign edge_r     = i_daclrck && !lrck_q;
    assign fifo_empty = (level_q == '0);
    assign o_ready    = (level_q != DEPTH_L);
    assign push       = i_valid && o_ready;
    assign head_l     = mem_l[rd_ptr_q];
    assign head_r     = mem_r[rd_ptr_q];

    // FIFO storage and occupancy; the head is read combinationally so a pop can load on the same edge
    always_ff @(posedge i_bclk) begin
        if (push) begin
            mem_l[wr_ptr_q] <= i_data_l;
            mem_r[wr_ptr_q] <= i_data_r;
        end
    end

    always_ff @(posedge i_bclk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        r_hold_d   = r_hold_q;
        bit_cnt_d  = bit_cnt_q;
        dac_d      = 1'b0;
        underrun_d = 1'b0;
        urun_cnt_d = urun_cnt_q;
        pop        = 1'b0;
        do_load    = 1'b0;
        load_word  = '0;

        // Serialise while inside a half-frame; once the word is out the slot is zero-padded
        if (state_q != ST_IDLE && bit_cnt_q != BITS_L) begin
            dac_d     = shift_q[DATA_W-1];
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BW'(1);
        end

        case (state_q)
            ST_IDLE, ST_RIGHT: begin
                if (edge_l) begin
                    if (i_en) begin
                        state_d = ST_LEFT;
                        do_load = 1'b1;
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            load_word = i_mute ? '0 : head_l;
                            r_hold_d  = i_mono ? head_l : head_r;
                        end else begin
                            load_word  = '0;
                            r_hold_d   = '0;
                            underrun_d = 1'b1;
                            if (urun_cnt_q != '1) begin
                                urun_cnt_d = urun_cnt_q + CNT_W'(1);
                            end
                        end
                    end else begin
                        state_d = ST_IDLE;
                        dac_d   = 1'b0;
                    end
                end
            end
            ST_LEFT: begin
                if (edge_r) begin
                    state_d   = ST_RIGHT;
                    do_load   = 1'b1;
                    load_word = i_mute ? '0 : r_hold_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load preempts any bits still pending from a short half-frame
        if (do_load) begin
            dac_d     = load_word[DATA_W-1];
            shift_d   = {load_word[DATA_W-2:0], 1'b0};
            bit_cnt_d = BW'(1);
        end
    end

    always_ff @(posedge i_bclk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            lrck_q     <= 1'b1;
            shift_q    <= '0;
            r_hold_q   <= '0;
            bit_cnt_q  <= '0;
            dac_q      <= 1'b0;
            underrun_q <= 1'b0;
            urun_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lrck_q     <= i_daclrck;
            shift_q    <= shift_d;
            r_hold_q   <= r_hold_d;
            bit_cnt_q  <= bit_cnt_d;
            dac_q      <= dac_d;
            underrun_q <= underrun_d;
            urun_cnt_q <= urun_cnt_d;
        end
    end

    assign o_aud_dacdat   = dac_q;
    assign o_underrun     = underrun_q;
    assign o_underrun_cnt = urun_cnt_q;
    assign o_level        = level_q;
    assign o_busy         = (state_q == ST_LEFT) || (state_q == ST_RIGHT);

endmodule

// File: tb/tb_aud_player_stereo.sv
// Directed bench for aud_player_stereo: a producer queue feeds pairs, the bench drives LRCK half-frames
// and compares captured serial words against hand-chosen sample values.
module tb_aud_player_stereo;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           daclrck = 1'b1;
    logic           en = 1'b0;
    logic           mute = 1'b0;
    logic           mono = 1'b0;
    logic           valid = 1'b0;
    logic [DW-1:0]  data_l = '0;
    logic [DW-1:0]  data_r = '0;

    logic           ready, dac, underrun, busy;
    logic [7:0]     ucnt;
    logic [LW-1:0]  level;
    logic           s_ready, s_dac, s_underrun, s_busy;
    logic [1:0]     s_ucnt;
    logic [LW-1:0]  s_level;

    aud_player_stereo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(8)) u_dut (
        .i_bclk(clk), .i_rst(rst), .i_daclrck(daclrck), .i_en(en), .i_mute(mute), .i_mono(mono),
        .i_valid(valid), .i_data_l(data_l), .i_data_r(data_r),
        .o_ready(ready), .o_aud_dacdat(dac), .o_underrun(underrun), .o_underrun_cnt(ucnt),
        .o_level(level), .o_busy(busy)
    );

    // Second instance with a 2-bit counter to observe saturation under the same stimulus
    aud_player_stereo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(2)) u_sat (
        .i_bclk(clk), .i_rst(rst), .i_daclrck(daclrck), .i_en(en), .i_mute(mute), .i_mono(mono),
        .i_valid(valid), .i_data_l(data_l), .i_data_r(data_r),
        .o_ready(s_ready), .o_aud_dacdat(s_dac), .o_underrun(s_underrun), .o_underrun_cnt(s_ucnt),
        .o_level(s_level), .o_busy(s_busy)
    );

    int total = 0;
    int bad = 0;
    int accepted = 0;
    logic [DW-1:0] pend_l[$];
    logic [DW-1:0] pend_r[$];
    int            upulses;
    logic [LW-1:0] lvl1, lvl2;
    logic          busy1, rdy1;

    function automatic logic [31:0] exp_bits(input logic [DW-1:0] w, input int s, input int n);
        logic [31:0] e;
        e = '0;
        for (int k = s; k < s + n; k++) begin
            e = {e[30:0], (k < DW) ? w[DW-1-k] : 1'b0};
        end
        return e;
    endfunction

    // One bclk; the producer sees its pair taken if valid and ready both held at the rising edge
    task automatic step();
        logic rdy;
        rdy = ready;
        @(negedge clk);
        if (valid && rdy) begin
            void'(pend_l.pop_front());
            void'(pend_r.pop_front());
            accepted++;
        end
        if (pend_l.size() > 0) begin
            valid  = 1'b1;
            data_l = pend_l[0];
            data_r = pend_r[0];
        end else begin
            valid = 1'b0;
        end
    endtask

    task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r);
        pend_l.push_back(l);
        pend_r.push_back(r);
        if (!valid) begin
            valid  = 1'b1;
            data_l = l;
            data_r = r;
        end
    endtask

    task automatic half(input logic lev, input int n, output logic [31:0] got);
        got = '0;
        upulses = 0;
        daclrck = lev;
        for (int k = 0; k < n; k++) begin
            step();
            got = {got[30:0], dac};
            if (underrun) upulses++;
            if (k == 0) begin
                lvl1  = level;
                busy1 = busy;
                rdy1  = ready;
            end
            if (k == 1) lvl2 = level;
        end
        $display("half lrck=%0b n=%0d bits=%h level=%0d ucnt=%0d", lev, n, got, level, ucnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        daclrck = 1'b1;
        en = 1'b0;
        mute = 1'b0;
        mono = 1'b0;
        pend_l.delete();
        pend_r.delete();
        valid = 1'b0;
        accepted = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (dac !== 1'b0)   begin bad++; $display("FAIL reset_dac got=%b exp=0", dac); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        total++; if (ucnt !== 8'd0)  begin bad++; $display("FAIL reset_ucnt got=%0d exp=0", ucnt); end
        total++; if (level !== '0)   begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        step();
        total++; if (busy !== 1'b0 || dac !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset busy=%b dac=%b exp 0/0", busy, dac);
        end
    endtask

    task automatic test_basic();
        logic [31:0] g;
        do_reset();
        en = 1'b1;
        offer(16'hA5F0, 16'h0FF1);
        step();
        total++; if (level !== 3'd1) begin bad++; $display("FAIL basic_level_push got=%0d exp=1", level); end
        half(1'b0, 20, g);
        total++; if (g !== exp_bits(16'hA5F0, 0, 20)) begin
            bad++; $display("FAIL basic_left got=%h exp=%h", g, exp_bits(16'hA5F0, 0, 20));
        end
        total++; if (lvl1 !== 3'd0) begin bad++; $display("FAIL basic_level_pop got=%0d exp=0", lvl1); end
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy1); end
        half(1'b1, 20, g);
        total++; if (g !== exp_bits(16'h0FF1, 0, 20)) begin
            bad++; $display("FAIL basic_right got=%h exp=%h", g, exp_bits(16'h0FF1, 0, 20));
        end
    endtask

    task automatic test_underrun();
        logic [31:0] g;
        do_reset();
        en = 1'b1;
        for (int f = 1; f <= 7; f++) begin
            if (f == 3) offer(16'h6C93, 16'h0F0F);
            half(1'b0, 16, g);
            if (f == 4) begin
                total++; if (g !== exp_bits(16'h6C93, 0, 16) || upulses != 0) begin
                    bad++; $display("FAIL urun_pop_left f=%0d got=%h pulses=%0d exp=%h/0", f, g, upulses, exp_bits(16'h6C93, 0, 16));
                end
            end else begin
                total++; if (g !== 32'd0 || upulses != 1) begin
                    bad++; $display("FAIL urun_left f=%0d got=%h pulses=%0d exp=0/1", f, g, upulses);
                end
            end
            if (f == 3) begin
                total++; if (lvl1 !== 3'd1) begin bad++; $display("FAIL urun_push_same_edge level=%0d exp=1", lvl1); end
            end
            half(1'b1, 16, g);
            total++; if (g !== ((f == 4) ? exp_bits(16'h0F0F, 0, 16) : 32'd0)) begin
                bad++; $display("FAIL urun_right f=%0d got=%h", f, g);
            end
            if (f == 2) begin
                total++; if (ucnt !== 8'd2 || s_ucnt !== 2'd2) begin
                    bad++; $display("FAIL urun_cnt2 got=%0d/%0d exp=2/2", ucnt, s_ucnt);
                end
            end
        end
        total++; if (ucnt !== 8'd6) begin bad++; $display("FAIL urun_cnt got=%0d exp=6", ucnt); end
        total++; if (s_ucnt !== 2'd3) begin bad++; $display("FAIL urun_sat got=%0d exp=3", s_ucnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] g;
        logic [DW-1:0] pl[5];
        logic [DW-1:0] pr[5];
        pl = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        pr = '{16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        do_reset();
        for (int i = 0; i < 5; i++) offer(pl[i], pr[i]);
        for (int i = 0; i < 7; i++) step();
        total++; if (ready !== 1'b0 || level !== 3'd4 || accepted != 4) begin
            bad++; $display("FAIL b2b_full ready=%b level=%0d acc=%0d exp 0/4/4", ready, level, accepted);
        end
        en = 1'b1;
        half(1'b0, 16, g);
        total++; if (lvl1 !== 3'd3 || rdy1 !== 1'b1) begin
            bad++; $display("FAIL b2b_pop level=%0d ready=%b exp 3/1", lvl1, rdy1);
        end
        total++; if (lvl2 !== 3'd4 || accepted != 5) begin
            bad++; $display("FAIL b2b_fifth level=%0d acc=%0d exp 4/5", lvl2, accepted);
        end
        total++; if (g !== exp_bits(pl[0], 0, 16)) begin bad++; $display("FAIL b2b_l0 got=%h exp=%h", g, pl[0]); end
        half(1'b1, 16, g);
        total++; if (g !== exp_bits(pr[0], 0, 16)) begin bad++; $display("FAIL b2b_r0 got=%h exp=%h", g, pr[0]); end
        for (int i = 1; i < 5; i++) begin
            half(1'b0, 16, g);
            total++; if (g !== exp_bits(pl[i], 0, 16)) begin bad++; $display("FAIL b2b_l%0d got=%h exp=%h", i, g, pl[i]); end
            half(1'b1, 16, g);
            total++; if (g !== exp_bits(pr[i], 0, 16)) begin bad++; $display("FAIL b2b_r%0d got=%h exp=%h", i, g, pr[i]); end
        end
        half(1'b0, 16, g);
        total++; if (upulses != 1) begin bad++; $display("FAIL b2b_drained pulses=%0d exp=1", upulses); end
    endtask

    task automatic test_mono_mute();
        logic [31:0] g;
        do_reset();
        en = 1'b1;
        mono = 1'b1;
        offer(16'h8001, 16'h1234);
        offer(16'hABCD, 16'h1357);
        step();
        step();
        half(1'b0, 16, g);
        total++; if (g !== exp_bits(16'h8001, 0, 16)) begin bad++; $display("FAIL mono_left got=%h exp=8001", g); end
        half(1'b1, 16, g);
        total++; if (g !== exp_bits(16'h8001, 0, 16)) begin bad++; $display("FAIL mono_right got=%h exp=8001", g); end
        mono = 1'b0;
        mute = 1'b1;
        half(1'b0, 16, g);
        total++; if (g !== 32'd0 || lvl1 !== 3'd0) begin
            bad++; $display("FAIL mute_left got=%h level=%0d exp 0/0", g, lvl1);
        end
        half(1'b1, 16, g);
        total++; if (g !== 32'd0) begin bad++; $display("FAIL mute_right got=%h exp=0", g); end
        mute = 1'b0;
    endtask

    task automatic test_en_drop_and_reset();
        logic [31:0] g;
        do_reset();
        en = 1'b1;
        offer(16'hC3A5, 16'h5A3C);
        offer(16'h7E81, 16'h03FF);
        step();
        step();
        half(1'b0, 5, g);
        total++; if (g !== exp_bits(16'hC3A5, 0, 5)) begin bad++; $display("FAIL endrop_l_head got=%h", g); end
        en = 1'b0;
        half(1'b0, 11, g);
        total++; if (g !== exp_bits(16'hC3A5, 5, 11)) begin bad++; $display("FAIL endrop_l_tail got=%h exp=%h", g, exp_bits(16'hC3A5, 5, 11)); end
        half(1'b1, 20, g);
        total++; if (g !== exp_bits(16'h5A3C, 0, 20)) begin bad++; $display("FAIL endrop_right got=%h", g); end
        half(1'b0, 10, g);
        total++; if (g !== 32'd0 || lvl1 !== 3'd1 || busy1 !== 1'b0 || upulses != 0) begin
            bad++; $display("FAIL endrop_idle got=%h level=%0d busy=%b pulses=%0d exp 0/1/0/0", g, lvl1, busy1, upulses);
        end
        en = 1'b1;
        half(1'b1, 4, g);
        total++; if (g !== 32'd0 || busy1 !== 1'b0) begin bad++; $display("FAIL idle_ignores_r got=%h busy=%b", g, busy1); end
        half(1'b0, 16, g);
        total++; if (g !== exp_bits(16'h7E81, 0, 16)) begin bad++; $display("FAIL resume_left got=%h exp=7E81", g); end
        offer(16'hFFFF, 16'hFFFF);
        half(1'b1, 6, g);
        total++; if (level !== 3'd1) begin bad++; $display("FAIL pre_reset_level got=%0d exp=1", level); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (dac !== 1'b0 || level !== '0 || busy !== 1'b0 || ready !== 1'b1) begin
            bad++; $display("FAIL midframe_reset dac=%b level=%0d busy=%b ready=%b exp 0/0/0/1", dac, level, busy, ready);
        end
        step();
        total++; if (dac !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL post_reset dac=%b busy=%b", dac, busy); end
    endtask

    task automatic test_short_half();
        logic [31:0] g;
        logic [DW-1:0] pl[4];
        logic [DW-1:0] pr[4];
        pl = '{16'hA5F0, 16'h1234, 16'h9ABC, 16'h8001};
        pr = '{16'h0FF1, 16'h5678, 16'hDEF0, 16'h7FFE};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 4; i++) offer(pl[i], pr[i]);
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 4; i++) begin
            half(1'b0, 10, g);
            total++; if (g !== exp_bits(pl[i], 0, 10)) begin bad++; $display("FAIL short_l%0d got=%h exp=%h", i, g, exp_bits(pl[i], 0, 10)); end
            half(1'b1, 10, g);
            total++; if (g !== exp_bits(pr[i], 0, 10)) begin bad++; $display("FAIL short_r%0d got=%h exp=%h", i, g, exp_bits(pr[i], 0, 10)); end
        end
        total++; if (level !== 3'd0 || ucnt !== 8'd0) begin bad++; $display("FAIL short_end level=%0d ucnt=%0d exp 0/0", level, ucnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_mono_mute();
        test_en_drop_and_reset();
        test_short_half();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
